// File: rtl/trojan_cap_pkg.sv
// Shared types and defaults for the trojan-harness response capture stage.
package trojan_cap_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WARMUP  = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } cap_state_e;

  localparam int unsigned DEF_SIG_W = 16;
  localparam logic [15:0] DEF_POLY  = 16'h1021;

endpackage

// File: rtl/serial_misr.sv
// Serial-input signature register: shifts left and folds in POLY when the
// outgoing MSB differs from the incoming bit.
module serial_misr #(
  parameter int unsigned       SIG_W   = 16,
  parameter logic [SIG_W-1:0]  POLY    = SIG_W'(16'h1021),
  parameter logic [SIG_W-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [SIG_W-1:0] seed,
  input  logic             bit_in,
  output logic [SIG_W-1:0] sig
);

  logic             fb;
  logic [SIG_W-1:0] sig_nxt;

  always_comb begin
    fb      = sig[SIG_W-1] ^ bit_in;
    sig_nxt = {sig[SIG_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  end

  // clr wins over en so a run always begins from seed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= RST_VAL;
    end else if (clr) begin
      sig <= seed;
    end else if (en) begin
      sig <= sig_nxt;
    end
  end

endmodule

// File: rtl/trojan_resp_capture.sv
// Response capture: skips SKIP warm-up cycles, compacts WINDOW samples into a
// signature plus ones count, then holds the result until the consumer takes it.
module trojan_resp_capture
  import trojan_cap_pkg::*;
#(
  parameter int unsigned      SIG_W  = DEF_SIG_W,
  parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED   = '0,
  parameter int unsigned      WINDOW = 1000,
  parameter int unsigned      SKIP   = 1,
  parameter int unsigned      CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  input  logic             resp_in,
  output logic             busy,
  output logic             sig_valid,
  input  logic             sig_ready,
  output logic [SIG_W-1:0] sig_out,
  output logic [CNT_W-1:0] ones_cnt,
  output logic [CNT_W-1:0] sample_cnt
);

  localparam int unsigned WU_W = $clog2(SKIP + 2);

  cap_state_e       state_q, state_d;
  logic [WU_W-1:0]  warm_q, warm_d;
  logic [CNT_W-1:0] ones_d, samp_d;
  logic             misr_en, misr_clr;
  logic             busy_d, valid_d;

  serial_misr #(
    .SIG_W  (SIG_W),
    .POLY   (POLY),
    .RST_VAL(SEED)
  ) u_misr (
    .clk   (CK),
    .rst   (reset),
    .en    (misr_en),
    .clr   (misr_clr),
    .seed  (SEED),
    .bit_in(resp_in),
    .sig   (sig_out)
  );

  // Next state, counter updates and flag decode from the next state
  always_comb begin
    state_d  = state_q;
    warm_d   = warm_q;
    ones_d   = ones_cnt;
    samp_d   = sample_cnt;
    misr_en  = 1'b0;
    misr_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          misr_clr = 1'b1;
          ones_d   = '0;
          samp_d   = '0;
          if (SKIP != 0) begin
            state_d = WARMUP;
            warm_d  = WU_W'(SKIP);
          end else begin
            state_d = CAPTURE;
          end
        end
      end
      WARMUP: begin
        warm_d = warm_q - WU_W'(1);
        if (warm_q == WU_W'(1)) state_d = CAPTURE;
      end
      CAPTURE: begin
        misr_en = 1'b1;
        ones_d  = ones_cnt + CNT_W'(resp_in);
        samp_d  = sample_cnt + CNT_W'(1);
        if (sample_cnt == CNT_W'(WINDOW - 1)) state_d = HOLD;
      end
      HOLD: begin
        if (sig_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d == WARMUP) || (state_d == CAPTURE);
    valid_d = (state_d == HOLD);
  end

  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      warm_q     <= '0;
      ones_cnt   <= '0;
      sample_cnt <= '0;
      busy       <= 1'b0;
      sig_valid  <= 1'b0;
    end else begin
      state_q    <= state_d;
      warm_q     <= warm_d;
      ones_cnt   <= ones_d;
      sample_cnt <= samp_d;
      busy       <= busy_d;
      sig_valid  <= valid_d;
    end
  end

endmodule

// File: tb/tb_trojan_resp_capture.sv
// Bench for trojan_resp_capture: three configurations share one stimulus
// stream, each checked every cycle against a cycle-count based model.
module tb_trojan_resp_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic resp = 1'b0;
  logic ready = 1'b0;
  bit   chk_en = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  logic b0, v0, b1, v1, b2, v2;
  logic [15:0] s0, s1, s2;
  logic [9:0]  o0, n0;
  logic [0:0]  o1, n1;
  logic [1:0]  o2, n2;

  trojan_resp_capture #(.WINDOW(1000), .SKIP(1)) u0 (
    .CK(clk), .reset(rst), .start(start), .resp_in(resp), .busy(b0),
    .sig_valid(v0), .sig_ready(ready), .sig_out(s0), .ones_cnt(o0), .sample_cnt(n0));
  trojan_resp_capture #(.WINDOW(1), .SKIP(1)) u1 (
    .CK(clk), .reset(rst), .start(start), .resp_in(resp), .busy(b1),
    .sig_valid(v1), .sig_ready(ready), .sig_out(s1), .ones_cnt(o1), .sample_cnt(n1));
  trojan_resp_capture #(.WINDOW(2), .SKIP(0)) u2 (
    .CK(clk), .reset(rst), .start(start), .resp_in(resp), .busy(b2),
    .sig_valid(v2), .sig_ready(ready), .sig_out(s2), .ones_cnt(o2), .sample_cnt(n2));

  // Model: a run is a count of edges since the start edge; samples are the
  // edges numbered SKIP+1 .. SKIP+WINDOW, after which the result is offered.
  int          m_win  [3] = '{1000, 1, 2};
  int          m_skip [3] = '{1, 1, 0};
  bit          m_run  [3];
  bit          m_valid[3];
  int          m_c    [3];
  int          m_ones [3];
  int          m_samp [3];
  logic [15:0] m_sig  [3];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_run[i] <= 1'b0; m_valid[i] <= 1'b0; m_c[i] <= 0;
        m_ones[i] <= 0; m_samp[i] <= 0; m_sig[i] <= 16'h0000;
      end else if (m_valid[i]) begin
        if (ready) m_valid[i] <= 1'b0;
      end else if (m_run[i]) begin
        m_c[i] <= m_c[i] + 1;
        if (m_c[i] + 1 > m_skip[i]) begin
          m_sig[i]  <= {m_sig[i][14:0], 1'b0} ^ ((m_sig[i][15] ^ resp) ? 16'h1021 : 16'h0000);
          m_ones[i] <= m_ones[i] + (resp ? 1 : 0);
          m_samp[i] <= m_samp[i] + 1;
          if (m_samp[i] + 1 == m_win[i]) begin
            m_valid[i] <= 1'b1;
            m_run[i]   <= 1'b0;
          end
        end
      end else if (start) begin
        m_run[i] <= 1'b1; m_c[i] <= 0; m_ones[i] <= 0;
        m_samp[i] <= 0; m_sig[i] <= 16'h0000;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int i, input logic b, input logic v, input logic [15:0] s,
                          input logic [31:0] o, input logic [31:0] n);
    chk($sformatf("u%0d busy", i), 32'(b), 32'(m_run[i]));
    chk($sformatf("u%0d sig_valid", i), 32'(v), 32'(m_valid[i]));
    chk($sformatf("u%0d sig_out", i), 32'(s), 32'(m_sig[i]));
    chk($sformatf("u%0d ones_cnt", i), o, 32'(m_ones[i]));
    chk($sformatf("u%0d sample_cnt", i), n, 32'(m_samp[i]));
    chk($sformatf("u%0d busy_and_valid", i), 32'(b & v), 32'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (chk_en) begin
        cmp_inst(0, b0, v0, s0, 32'(o0), 32'(n0));
        cmp_inst(1, b1, v1, s1, 32'(o1), 32'(n1));
        cmp_inst(2, b2, v2, s2, 32'(o2), 32'(n2));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    bit done;
    repeat (2) @(posedge clk);
    #2;
    chk_en = 1'b1;
    chk("reset u0 sig_out", 32'(s0), 32'h0);
    chk("reset u0 busy", 32'(b0), 32'h0);
    chk("reset u0 sig_valid", 32'(v0), 32'h0);
    @(negedge clk) rst = 1'b0;

    // Window 1 / window 2 with all-ones response; result held with ready low
    @(negedge clk) begin start = 1'b1; resp = 1'b1; end
    tick();
    chk("w1 busy after start", 32'(b1), 32'h1);
    chk("w1 valid after start", 32'(v1), 32'h0);
    @(negedge clk) start = 1'b0;
    tick();
    chk("w1 valid one edge after start", 32'(v1), 32'h0);
    tick();
    chk("w1 valid two edges after start", 32'(v1), 32'h1);
    chk("w1 sig", 32'(s1), 32'h1021);
    chk("w1 ones", 32'(o1), 32'h1);
    chk("w1 samples", 32'(n1), 32'h1);
    chk("w2 valid", 32'(v2), 32'h1);
    chk("w2 sig ones", 32'(s2), 32'h3063);
    chk("w2 ones", 32'(o2), 32'h2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) start = (i % 2 == 0);
      tick();
      chk("hold w1 valid", 32'(v1), 32'h1);
      chk("hold w1 sig", 32'(s1), 32'h1021);
    end
    @(negedge clk) start = 1'b0;

    // Abort the long run after 400 samples
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      tick();
      if (n0 == 10'd400) done = 1'b1;
    end
    chk("u0 reached 400 samples", 32'(done), 32'h1);
    @(negedge clk) rst = 1'b1;
    tick();
    chk("abort busy", 32'(b0), 32'h0);
    chk("abort valid", 32'(v0), 32'h0);
    chk("abort sig", 32'(s0), 32'h0);
    chk("abort samples", 32'(n0), 32'h0);
    chk("abort ones", 32'(o0), 32'h0);
    @(negedge clk) rst = 1'b0;
    repeat (20) tick();
    chk("no result after abort", 32'(v0), 32'h0);

    // Response high only during the warm-up edge
    ready = 1'b1;
    @(negedge clk) begin start = 1'b1; resp = 1'b0; end
    @(negedge clk) begin start = 1'b0; resp = 1'b1; end
    @(negedge clk) resp = 1'b0;
    tick();
    chk("skip0 w2 valid", 32'(v2), 32'h1);
    chk("skip0 w2 sig", 32'(s2), 32'h2042);
    chk("skip0 w2 ones", 32'(o2), 32'h1);
    chk("warmup w1 sig", 32'(s1), 32'h0);
    done = 1'b0;
    for (int i = 0; i < 1100 && !done; i++) begin
      tick();
      if (v0) done = 1'b1;
    end
    chk("warmup u0 done", 32'(done), 32'h1);
    chk("warmup u0 sig", 32'(s0), 32'h0);
    chk("warmup u0 ones", 32'(o0), 32'h0);
    chk("warmup u0 samples", 32'(n0), 32'd1000);

    // Zeros into window 2, then ready+start in the same HOLD cycle
    ready = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      if (v2) done = 1'b1; else tick();
    end
    chk("zeros w2 done", 32'(done), 32'h1);
    chk("zeros w2 sig", 32'(s2), 32'h0);
    chk("zeros w2 ones", 32'(o2), 32'h0);
    @(negedge clk) begin ready = 1'b1; start = 1'b1; end
    tick();
    chk("b2b release valid", 32'(v2), 32'h0);
    chk("b2b start ignored", 32'(b2), 32'h0);
    @(negedge clk) begin ready = 1'b0; start = 1'b1; end
    tick();
    chk("b2b restart busy", 32'(b2), 32'h1);
    chk("b2b restart samples", 32'(n2), 32'h0);
    @(negedge clk) start = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      tick();
      if (v2) done = 1'b1;
    end
    chk("b2b w2 done", 32'(done), 32'h1);
    chk("b2b w2 sig repeat", 32'(s2), 32'h0);
    chk("b2b w2 samples", 32'(n2), 32'h2);

    // Mixed pattern into the long run until it completes
    ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 1100 && !done; i++) begin
      @(negedge clk) resp = (i % 3 == 0);
      tick();
      if (v0) done = 1'b1;
    end
    chk("pattern u0 done", 32'(done), 32'h1);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
